// File: rtl/bit_generator.sv
// bit_generator: WS2812B serial symbol generator (100 MHz clock).
// Emits one timed symbol per request on theBit: data "0", data "1" or a RET
// low period, back-to-back while doGen stays high. genDone pulses during the
// last cycle of every completed symbol.
// Optional build macro BITGEN_INVERT_EN: drive theBit inverted (idle high)
// for an inverting level shifter; genDone timing is unaffected.
module bit_generator #(
  parameter int T0H_CYC = 40,
  parameter int T1H_CYC = 80,
  parameter int BIT_CYC = 125,
  parameter int RET_CYC = 5000,
  parameter int CNT_W   = 13
) (
  input  logic       clk,
  input  logic       reset,
  output logic       theBit,
  output logic       genDone,
  input  logic [1:0] genMode,
  input  logic       doGen
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] T0H_K    = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_K    = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BITGEN_INVERT_EN
  localparam logic LINE_INV = 1'b1;
`else
  localparam logic LINE_INV = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_bit;
  logic             w_bit_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // Index of the last cycle of a symbol; RET is long, all other modes
  // (including the invalid 01) last one data-bit period.
  function automatic logic [CNT_W-1:0] sym_last(input logic [1:0] mode);
    logic [CNT_W-1:0] last;
    case (mode)
      2'b00:   last = RET_LAST;
      default: last = BIT_LAST;
    endcase
    return last;
  endfunction

  // Line level (before optional inversion) at cycle k of a symbol.
  function automatic logic sym_level(input logic [1:0] mode, input logic [CNT_W-1:0] k);
    logic lvl;
    case (mode)
      2'b11:   lvl = (k < T1H_K);
      2'b10:   lvl = (k < T0H_K);
      default: lvl = 1'b0;
    endcase
    return lvl;
  endfunction

  // Next-state, counter and output decode; outputs are computed for the
  // cycle about to start so they can be registered with no start latency.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = LINE_INV;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (doGen) begin
          w_state_nxt = ST_ACTIVE;
          w_mode_nxt  = genMode;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_ACTIVE: begin
        if (r_cnt == sym_last(r_mode)) begin
          if (doGen) begin
            // Seamless restart: genMode is sampled only here.
            w_state_nxt = ST_ACTIVE;
            w_mode_nxt  = genMode;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_state_nxt == ST_ACTIVE) begin
      w_bit_nxt  = sym_level(w_mode_nxt, w_cnt_nxt) ^ LINE_INV;
      w_done_nxt = (w_cnt_nxt == sym_last(w_mode_nxt));
    end else begin
      w_bit_nxt  = LINE_INV;
      w_done_nxt = 1'b0;
    end
  end

  // State, counter, latched mode and registered outputs; reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'b00;
      r_cnt   <= '0;
      r_bit   <= LINE_INV;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign theBit  = r_bit;
  assign genDone = r_done;

endmodule

// File: tb/tb_bit_generator.sv
// tb_bit_generator: directed self-checking bench for bit_generator.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// so the k-th falling edge after a start edge observes symbol cycle k.
module tb_bit_generator;

`ifdef BITGEN_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       theBit;
  logic       genDone;
  logic [1:0] genMode;
  logic       doGen;

  int n_checks;
  int n_fails;

  bit_generator dut (
    .clk     (clk),
    .reset   (reset),
    .theBit  (theBit),
    .genDone (genDone),
    .genMode (genMode),
    .doGen   (doGen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Observe one whole symbol: theBit high (unmodified polarity) for k < hi,
  // genDone only on k == len-1. Optionally change genMode or drop doGen
  // right after observing cycle chg_k / drop_k.
  task automatic run_symbol(input string name, input int hi, input int len,
                            input int chg_k, input logic [1:0] chg_mode,
                            input int drop_k);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check($sformatf("%s bit k=%0d", name, k), {31'd0, theBit},
            {31'd0, ((k < hi) ? 1'b1 : 1'b0) ^ INV});
      check($sformatf("%s done k=%0d", name, k), {31'd0, genDone},
            {31'd0, (k == len - 1) ? 1'b1 : 1'b0});
      if (k == chg_k) genMode = chg_mode;
      if (k == drop_k) doGen = 1'b0;
    end
  endtask

  // Check the idle condition for a number of cycles.
  task automatic check_idle(input string name, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check($sformatf("%s bit c=%0d", name, k), {31'd0, theBit}, {31'd0, INV});
      check($sformatf("%s done c=%0d", name, k), {31'd0, genDone}, 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    doGen    = 1'b0;
    genMode  = 2'b00;

    // Reset held two cycles with doGen low.
    check_idle("reset", 2);
    reset = 1'b0;
    check_idle("post_reset", 3);

    // Back-to-back symbols with doGen held high; mode changes mid-symbol
    // only affect the following symbol.
    genMode = 2'b11;
    doGen   = 1'b1;
    run_symbol("one_a",  80, 125,  -1, 2'b11, -1);
    run_symbol("one_b",  80, 125, 100, 2'b10, -1);
    run_symbol("zero",   40, 125,  60, 2'b11, -1);
    run_symbol("one_c",  80, 125,  10, 2'b00, -1);
    run_symbol("ret",     0, 5000, 10, 2'b01, -1);
    run_symbol("inval",   0, 125,  10, 2'b11, -1);
    run_symbol("one_d",  80, 125,  -1, 2'b11, 30);
    check_idle("after_drop", 10);

    // Reset in the middle of a "1" bit aborts it without a done pulse.
    genMode = 2'b11;
    doGen   = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      check($sformatf("abort bit k=%0d", k), {31'd0, theBit},
            {31'd0, 1'b1 ^ INV});
      check($sformatf("abort done k=%0d", k), {31'd0, genDone}, 32'd0);
    end
    reset = 1'b1;
    doGen = 1'b0;
    check_idle("mid_reset", 1);
    reset = 1'b0;
    check_idle("no_done_after_reset", 150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
